// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with 16x oversampling, one-entry holding register and
// sticky overrun / framing-error flags for the peripheral bus.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling start edge
// ST_START | timing to the start-bit centre to confirm a real start bit
// ST_DATA  | sampling eight data bits LSB first at each bit centre
// ST_STOP  | sampling the stop bit; good byte loads, low stop flags error
// ST_BREAK | line held low after a framing error; wait for it to rise
module uart_rx_ctrl #(
    parameter int unsigned OVS_DIV = 651
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       rx_read,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int unsigned OVS = 16;
    localparam int unsigned TW  = (OVS_DIV > 2) ? $clog2(OVS_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(OVS_DIV - 1);
    localparam logic [3:0]    SAMP_MID  = 4'(OVS / 2 - 1);
    localparam logic [3:0]    SAMP_LAST = 4'(OVS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          rx_meta;
    logic          rx_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    samp_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;

    logic mid_bit;
    logic bit_end;
    logic start_ok;
    logic start_bad;
    logic data_shift;
    logic stop_chk;
    logic load;
    logic frame_bad;

    // The pin is asynchronous; only the second flop is used downstream.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick = (state != ST_IDLE) && (tick_cnt == TICK_LAST);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (state == ST_IDLE || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign mid_bit    = tick && (samp_cnt == SAMP_MID);
    assign bit_end    = tick && (samp_cnt == SAMP_LAST);
    assign start_ok   = (state == ST_START) && mid_bit && !rx_s;
    assign start_bad  = (state == ST_START) && mid_bit && rx_s;
    assign data_shift = (state == ST_DATA) && bit_end;
    assign stop_chk   = (state == ST_STOP) && bit_end;
    assign load       = stop_chk && rx_s;
    assign frame_bad  = stop_chk && !rx_s;

    // Re-zeroing at the start-bit centre makes every later 16th tick a bit centre.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            samp_cnt <= '0;
        end else if (state == ST_IDLE || start_ok) begin
            samp_cnt <= '0;
        end else if (tick) begin
            samp_cnt <= samp_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
        end else if (state == ST_IDLE || start_ok) begin
            bit_cnt <= '0;
        end else if (data_shift) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
        end else if (start_ok) begin
            shift_reg <= '0;
        end else if (data_shift) begin
            shift_reg[bit_cnt] <= rx_s;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (start_ok) begin
                    state_nxt = ST_DATA;
                end else if (start_bad) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (data_shift && bit_cnt == 3'd7) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (load) begin
                    state_nxt = ST_IDLE;
                end else if (frame_bad) begin
                    state_nxt = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_busy = (state != ST_IDLE);
    end

    // A load outranks a same-cycle read, so the new byte is never lost.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (load) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end

            if (load && rx_valid && !rx_read) begin
                rx_overrun <= 1'b1;
            end else if (err_clr) begin
                rx_overrun <= 1'b0;
            end

            if (frame_bad) begin
                rx_frame_err <= 1'b1;
            end else if (err_clr) begin
                rx_frame_err <= 1'b0;
            end
        end
    end

endmodule
